// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: shares the single-port data RAM between LSU lanes 0/1.
// Define LSU_ARB_FIXED_PRIO_EN to make lane 0 win every conflict.

module lsu_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              l0_rd_en,
  input  logic              l0_wr_en,
  input  logic [ADDR_W-1:0] l0_addr,
  input  logic [DATA_W-1:0] l0_wr_data,
  output logic [DATA_W-1:0] l0_rd_data,
  input  logic              l1_rd_en,
  input  logic              l1_wr_en,
  input  logic [ADDR_W-1:0] l1_addr,
  input  logic [DATA_W-1:0] l1_wr_data,
  output logic [DATA_W-1:0] l1_rd_data,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              arb_stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEFER = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mreq_t;

  state_t state;
  state_t state_nx;

  mreq_t lq0;
  mreq_t lq1;
  mreq_t win_q;
  mreq_t lose_q;
  mreq_t dbuf;
  mreq_t sel;

  logic req0;
  logic req1;
  logic both;
  logic conflict;
  logic rr_ptr;
  logic win_lane;
  logic win_rd;
  logic lose_pend;
  logic src0;
  logic src1;
  logic arb_c;

  logic [DATA_W-1:0] hold0;
  logic [DATA_W-1:0] hold1;

  // A lane with both enables set is a store; its read is dropped.
  assign lq0 = '{
    rd:   l0_rd_en & ~l0_wr_en,
    wr:   l0_wr_en,
    addr: l0_addr,
    data: l0_wr_data
  };

  assign lq1 = '{
    rd:   l1_rd_en & ~l1_wr_en,
    wr:   l1_wr_en,
    addr: l1_addr,
    data: l1_wr_data
  };

  assign req0 = l0_rd_en | l0_wr_en;
  assign req1 = l1_rd_en | l1_wr_en;
  assign both = req0 & req1;

  assign conflict = (state == IDLE)
                  & ~stall_in
                  & both;

  assign win_q  = rr_ptr ? lq1 : lq0;
  assign lose_q = rr_ptr ? lq0 : lq1;

`ifdef LSU_ARB_FIXED_PRIO_EN
  assign rr_ptr = 1'b0;
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= 1'b0;
    end else if (conflict) begin
      rr_ptr <= ~rr_ptr;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (conflict) begin
          state_nx = DEFER;
        end
      end
      DEFER: begin
        state_nx = stall_in ? HOLD : IDLE;
      end
      HOLD: begin
        state_nx = stall_in ? HOLD : IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    sel   = '0;
    arb_c = 1'b0;
    if (rst) begin
      unique case (state)
        IDLE: begin
          if (!stall_in) begin
            unique case (1'b1)
              both: begin
                sel   = win_q;
                arb_c = 1'b1;
              end
              (req0 & ~req1): begin
                sel = lq0;
              end
              (req1 & ~req0): begin
                sel = lq1;
              end
              default: begin
                sel = '0;
              end
            endcase
          end
        end
        DEFER: begin
          sel = dbuf;
        end
        default: begin
          sel = '0;
        end
      endcase
    end
  end

  assign mem_rd_en   = sel.rd;
  assign mem_wr_en   = sel.wr;
  assign mem_addr    = sel.addr;
  assign mem_wr_data = sel.data;
  assign arb_stall   = arb_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbuf      <= '0;
      win_lane  <= 1'b0;
      win_rd    <= 1'b0;
      lose_pend <= 1'b0;
      hold0     <= '0;
      hold1     <= '0;
      src0      <= 1'b0;
      src1      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          src0 <= 1'b0;
          src1 <= 1'b0;
          if (conflict) begin
            dbuf     <= lose_q;
            win_lane <= rr_ptr;
            win_rd   <= win_q.rd;
          end
        end
        DEFER: begin
          lose_pend <= dbuf.rd;
          if (win_rd & ~win_lane) begin
            hold0 <= mem_rd_data;
            src0  <= 1'b1;
          end
          if (win_rd & win_lane) begin
            hold1 <= mem_rd_data;
            src1  <= 1'b1;
          end
        end
        HOLD: begin
          // Loser's read data is only valid on the first HOLD cycle.
          if (lose_pend) begin
            lose_pend <= 1'b0;
            if (win_lane) begin
              hold0 <= mem_rd_data;
              src0  <= 1'b1;
            end else begin
              hold1 <= mem_rd_data;
              src1  <= 1'b1;
            end
          end
        end
        default: begin
          lose_pend <= 1'b0;
        end
      endcase
    end
  end

  assign l0_rd_data = src0 ? hold0 : mem_rd_data;
  assign l1_rd_data = src1 ? hold1 : mem_rd_data;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter: directed checks of lsu_mem_arbiter against a RAM model.
// Build with LSU_ARB_FIXED_PRIO_EN to expect lane 0 winning every conflict.

module tb_lsu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        l0_rd_en;
  logic        l0_wr_en;
  logic [31:0] l0_addr;
  logic [31:0] l0_wr_data;
  logic [31:0] l0_rd_data;
  logic        l1_rd_en;
  logic        l1_wr_en;
  logic [31:0] l1_addr;
  logic [31:0] l1_wr_data;
  logic [31:0] l1_rd_data;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data = '0;
  logic        arb_stall;

  int n_cmp  = 0;
  int n_err  = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int base;
  bit ram_ok = 1'b0;

  logic [31:0] ram [256];
  logic        w;

  always #5 clk = ~clk;

  lsu_mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_in   (stall_in),
    .l0_rd_en   (l0_rd_en),
    .l0_wr_en   (l0_wr_en),
    .l0_addr    (l0_addr),
    .l0_wr_data (l0_wr_data),
    .l0_rd_data (l0_rd_data),
    .l1_rd_en   (l1_rd_en),
    .l1_wr_en   (l1_wr_en),
    .l1_addr    (l1_addr),
    .l1_wr_data (l1_wr_data),
    .l1_rd_data (l1_rd_data),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data),
    .arb_stall  (arb_stall)
  );

  // Single-port RAM: read data valid the cycle after mem_rd_en, junk otherwise.
  always @(posedge clk) begin
    if (!ram_ok) begin
      for (int i = 0; i < 256; i++) begin
        ram[i] = 32'hA000_0000 | i;
      end
      ram_ok = 1'b1;
    end
    mem_rd_data <= mem_rd_en ? ram[mem_addr[7:0]] : 32'h0BAD_0BAD;
    if (mem_wr_en) begin
      ram[mem_addr[7:0]] = mem_wr_data;
      wr_cnt++;
    end
    if (mem_rd_en) begin
      rd_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic win(input int k);
`ifdef LSU_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return logic'(k % 2);
`endif
  endfunction

  function automatic logic [31:0] rv(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  task automatic clr();
    l0_rd_en   = 1'b0;
    l0_wr_en   = 1'b0;
    l0_addr    = '0;
    l0_wr_data = '0;
    l1_rd_en   = 1'b0;
    l1_wr_en   = 1'b0;
    l1_addr    = '0;
    l1_wr_data = '0;
  endtask

  task automatic ld2(input logic [31:0] a0, input logic [31:0] a1);
    l0_rd_en = 1'b1;
    l0_addr  = a0;
    l1_rd_en = 1'b1;
    l1_addr  = a1;
  endtask

  task automatic ld_conflict(input int k, input logic [31:0] a0,
                             input logic [31:0] a1);
    w = win(k);
    @(negedge clk);
    ld2(a0, a1);
    #1;
    chk("cf_t_addr", mem_addr, w ? a1 : a0);
    chk("cf_t_rd", mem_rd_en, 1'b1);
    chk("cf_t_stall", arb_stall, 1'b1);
    @(negedge clk);
    #1;
    chk("cf_t1_addr", mem_addr, w ? a0 : a1);
    chk("cf_t1_stall", arb_stall, 1'b0);
    @(negedge clk);
    clr();
    #1;
    chk("cf_t2_l0", l0_rd_data, rv(a0));
    chk("cf_t2_l1", l1_rd_data, rv(a1));
  endtask

  initial begin
    rst      = 1'b0;
    stall_in = 1'b0;
    clr();

    // Reset: outputs quiet even with a request present
    @(negedge clk);
    l0_rd_en = 1'b1;
    l0_addr  = 32'h40;
    #1;
    chk("rst_rd_en", mem_rd_en, 1'b0);
    chk("rst_wr_en", mem_wr_en, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_stall", arb_stall, 1'b0);
    @(negedge clk);
    clr();
    rst = 1'b1;

    // Single lane-0 load passes straight through
    @(negedge clk);
    l0_rd_en = 1'b1;
    l0_addr  = 32'h40;
    #1;
    chk("single_rd_en", mem_rd_en, 1'b1);
    chk("single_addr", mem_addr, 32'h40);
    chk("single_stall", arb_stall, 1'b0);
    @(negedge clk);
    clr();
    #1;
    chk("single_data", l0_rd_data, rv(32'h40));

    // Two load conflicts: lane 0 first, then round-robin to lane 1
    ld_conflict(0, 32'h10, 32'h20);
    ld_conflict(1, 32'h10, 32'h20);

    // Store (lane 0 wins) then load of the same address by lane 1
    base = wr_cnt;
    @(negedge clk);
    l0_wr_en   = 1'b1;
    l0_addr    = 32'h80;
    l0_wr_data = 32'hDEAD_BEEF;
    l1_rd_en   = 1'b1;
    l1_addr    = 32'h80;
    #1;
    chk("st_t_wr", mem_wr_en, 1'b1);
    chk("st_t_rd", mem_rd_en, 1'b0);
    chk("st_t_wdata", mem_wr_data, 32'hDEAD_BEEF);
    chk("st_t_stall", arb_stall, 1'b1);
    @(negedge clk);
    #1;
    chk("st_t1_rd", mem_rd_en, 1'b1);
    chk("st_t1_wr", mem_wr_en, 1'b0);
    chk("st_t1_addr", mem_addr, 32'h80);
    @(negedge clk);
    clr();
    #1;
    chk("st_l1_data", l1_rd_data, 32'hDEAD_BEEF);
    chk("st_wr_pulses", wr_cnt - base, 1);

    // Conflict followed by a three-cycle hazard stall
    w    = win(3);
    base = rd_cnt;
    @(negedge clk);
    ld2(32'h30, 32'h34);
    #1;
    chk("hs_t_addr", mem_addr, w ? 32'h34 : 32'h30);
    @(negedge clk);
    stall_in = 1'b1;
    #1;
    chk("hs_t1_addr", mem_addr, w ? 32'h30 : 32'h34);
    chk("hs_t1_rd", mem_rd_en, 1'b1);
    chk("hs_t1_stall", arb_stall, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("hs_hold_rd", mem_rd_en, 1'b0);
      chk("hs_hold_wr", mem_wr_en, 1'b0);
      chk("hs_hold_l0", l0_rd_data, rv(32'h30));
      chk("hs_hold_l1", l1_rd_data, rv(32'h34));
    end
    @(negedge clk);
    stall_in = 1'b0;
    #1;
    chk("hs_fall_rd", mem_rd_en, 1'b0);
    chk("hs_fall_l0", l0_rd_data, rv(32'h30));
    chk("hs_fall_l1", l1_rd_data, rv(32'h34));
    @(negedge clk);
    clr();
    #1;
    chk("hs_after_l0", l0_rd_data, rv(32'h30));
    chk("hs_after_l1", l1_rd_data, rv(32'h34));
    chk("hs_rd_pulses", rd_cnt - base, 2);

    // Reset during DEFER abandons the deferred store
    base = wr_cnt;
    @(negedge clk);
    l0_rd_en   = 1'b1;
    l0_addr    = 32'h50;
    l1_wr_en   = 1'b1;
    l1_addr    = 32'h54;
    l1_wr_data = 32'h1234_5678;
    #1;
    chk("rd_t_stall", arb_stall, 1'b1);
    chk("rd_t_addr", mem_addr, 32'h50);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rd_rst_rd", mem_rd_en, 1'b0);
    chk("rd_rst_wr", mem_wr_en, 1'b0);
    chk("rd_rst_addr", mem_addr, 32'h0);
    chk("rd_rst_wdata", mem_wr_data, 32'h0);
    chk("rd_rst_stall", arb_stall, 1'b0);
    @(negedge clk);
    clr();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rd_no_write", wr_cnt - base, 0);
    chk("rd_ram_kept", ram[8'h54], rv(32'h54));
    chk("rd_idle_rd", mem_rd_en, 1'b0);

    // Three back-to-back conflicts after reset
    for (int k = 0; k < 3; k++) begin
      w = win(k);
      @(negedge clk);
      ld2(32'h60, 32'h64);
      #1;
      if (k > 0) begin
        chk("b2b_l0", l0_rd_data, rv(32'h60));
        chk("b2b_l1", l1_rd_data, rv(32'h64));
      end
      chk("b2b_t_addr", mem_addr, w ? 32'h64 : 32'h60);
      chk("b2b_t_stall", arb_stall, 1'b1);
      @(negedge clk);
      #1;
      chk("b2b_t1_addr", mem_addr, w ? 32'h60 : 32'h64);
    end
    @(negedge clk);
    clr();
    #1;
    chk("b2b_end_l0", l0_rd_data, rv(32'h60));
    chk("b2b_end_l1", l1_rd_data, rv(32'h64));

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
